guess_tracker: RTL and testbench

//  Upstream stage of the difficulty FSM. Holds the secret number, synchronises and checks player

---
 rtl/guess_tracker.sv | 169 ++++++++++++++++
 tb/tb_guess_tracker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/guess_tracker.sv
// guess_tracker: holds the secret, synchronises and checks player guesses, and keeps the
// round / incorrect-guess counters and the per-round countdown timer for the difficulty FSM.
module guess_tracker #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter logic [6:0]  ROUND_TIME    = 7'd99,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       restart,
    input  logic       submit,
    input  logic [3:0] guess,
    input  logic [1:0] Max_digit,
    input  logic [1:0] WINorLOSE,
    output logic [3:0] round,
    output logic [2:0] incorrect_guesses,
    output logic [6:0] timer,
    output logic [1:0] hint
);

    localparam int unsigned TickW = $clog2(TICKS_PER_SEC);
    localparam logic [TickW-1:0] TickMax = TickW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        StNew,
        StPlay,
        StCheck,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [3:0]       secret_q, secret_d;
    logic [3:0]       guess_q, guess_d;
    logic [3:0]       round_q, round_d;
    logic [2:0]       inc_q, inc_d;
    logic [6:0]       timer_q, timer_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [1:0]       hint_q, hint_d;
    logic             sub_s1_q, sub_s2_q;

    logic       sub_pulse;
    logic       playing;
    logic       run_timer;
    logic [3:0] mask;

    assign sub_pulse = sub_s1_q & ~sub_s2_q;
    assign playing   = (WINorLOSE == 2'b11);
    assign run_timer = ((state_q == StPlay) && playing) || (state_q == StCheck);

    always_comb begin
        mask = 4'h3;
        case (Max_digit)
            2'd2:    mask = 4'h7;
            2'd3:    mask = 4'hF;
            default: mask = 4'h3;
        endcase
    end

    // Fibonacci LFSR, taps 8,6,5,4; free-running in every state.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d  = state_q;
        secret_d = secret_q;
        guess_d  = guess_q;
        round_d  = round_q;
        inc_d    = inc_q;
        timer_d  = timer_q;
        tick_d   = tick_q;
        hint_d   = hint_q;

        // Timer first so that a correct-guess reload below overrides a same-cycle decrement.
        if (run_timer) begin
            if (tick_q == TickMax) begin
                tick_d = '0;
                if (timer_q != 7'd0) begin
                    timer_d = timer_q - 7'd1;
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        unique case (state_q)
            StNew: begin
                if (!playing) begin
                    state_d = StDone;
                end else begin
                    secret_d = lfsr_q[3:0] & mask;
                    timer_d  = ROUND_TIME;
                    tick_d   = '0;
                    state_d  = StPlay;
                end
            end
            StPlay: begin
                if (!playing) begin
                    state_d = StDone;
                end else if (sub_pulse) begin
                    guess_d = guess;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = StPlay;
                if (guess_q > mask) begin
                    hint_d = 2'b00;
                end else if (guess_q == secret_q) begin
                    hint_d  = 2'b11;
                    inc_d   = 3'd0;
                    timer_d = ROUND_TIME;
                    tick_d  = '0;
                    state_d = StNew;
                    if (round_q != 4'd15) begin
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    hint_d = (guess_q < secret_q) ? 2'b01 : 2'b10;
                    if (inc_q != 3'd7) begin
                        inc_d = inc_q + 3'd1;
                    end
                end
                // The result above still commits when the game ends during CHECK.
                if (!playing) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StNew;
            end
        endcase
    end

    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state_q  <= StNew;
            lfsr_q   <= LFSR_SEED;
            secret_q <= 4'd0;
            guess_q  <= 4'd0;
            round_q  <= 4'd1;
            inc_q    <= 3'd0;
            timer_q  <= ROUND_TIME;
            tick_q   <= '0;
            hint_q   <= 2'b00;
            sub_s1_q <= 1'b0;
            sub_s2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            secret_q <= secret_d;
            guess_q  <= guess_d;
            round_q  <= round_d;
            inc_q    <= inc_d;
            timer_q  <= timer_d;
            tick_q   <= tick_d;
            hint_q   <= hint_d;
            sub_s1_q <= submit;
            sub_s2_q <= sub_s1_q;
        end
    end

    assign round             = round_q;
    assign incorrect_guesses = inc_q;
    assign timer             = timer_q;
    assign hint              = hint_q;

endmodule

// File: tb/tb_guess_tracker.sv
// Directed bench for guess_tracker: expectations are queued when a step is driven and
// popped/compared once the response is due.
module tb_guess_tracker;

    logic       clk;
    logic       restart;
    logic       submit;
    logic [3:0] guess;
    logic [1:0] Max_digit;
    logic [1:0] WINorLOSE;
    logic [3:0] round;
    logic [2:0] incorrect_guesses;
    logic [6:0] timer;
    logic [1:0] hint_w;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [3:0] round;
        logic [2:0] inc;
        logic [6:0] timer;
        logic       tchk;
        logic [1:0] hint;
    } exp_t;

    exp_t sb[$];

    // Seed A6 with Max_digit=1 gives secret = 6 & 3 = 2 in the first round after reset.
    guess_tracker #(
        .TICKS_PER_SEC(4),
        .ROUND_TIME   (7'd5),
        .LFSR_SEED    (8'hA6)
    ) dut (
        .clk              (clk),
        .restart          (restart),
        .submit           (submit),
        .guess            (guess),
        .Max_digit        (Max_digit),
        .WINorLOSE        (WINorLOSE),
        .round            (round),
        .incorrect_guesses(incorrect_guesses),
        .timer            (timer),
        .hint             (hint_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] r, input logic [2:0] inc,
                        input logic [6:0] t, input logic tchk, input logic [1:0] h);
        exp_t e;
        e.tag   = tag;
        e.round = r;
        e.inc   = inc;
        e.timer = t;
        e.tchk  = tchk;
        e.hint  = h;
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_round"}, 32'(round), 32'(e.round));
            chk({e.tag, "_inc"}, 32'(incorrect_guesses), 32'(e.inc));
            chk({e.tag, "_hint"}, 32'(hint_w), 32'(e.hint));
            if (e.tchk) chk({e.tag, "_timer"}, 32'(timer), 32'(e.timer));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves restart released just after a rising edge; the next edge runs NEW.
    task automatic do_reset(input string tag);
        step(1);
        restart = 1'b0;
        #1;
        push(tag, 4'd1, 3'd0, 7'd5, 1'b1, 2'b00);
        compare_front();
        step(2);
        restart = 1'b1;
    endtask

    // Response commits on the third edge after submit is driven; two idle cycles follow.
    task automatic try_guess(input logic [3:0] g, input string tag, input logic [3:0] r,
                             input logic [2:0] inc, input logic [6:0] t, input logic tchk,
                             input logic [1:0] h);
        guess  = g;
        submit = 1'b1;
        push(tag, r, inc, t, tchk, h);
        step(2);
        submit = 1'b0;
        step(1);
        compare_front();
        step(2);
    endtask

    initial begin
        int t;
        restart   = 1'b0;
        submit    = 1'b0;
        guess     = 4'd0;
        Max_digit = 2'd1;
        WINorLOSE = 2'b11;

        // 1: reset values, then timer countdown with no guesses
        do_reset("t1_reset");
        for (int i = 0; i < 24; i++) begin
            step(1);
            t = 5 - i / 4;
            if (t < 0) t = 0;
            push($sformatf("t1_cyc%0d", i), 4'd1, 3'd0, 7'(t), 1'b1, 2'b00);
            compare_front();
        end

        // 2: secret=2, timer already at 0 so wrong guesses leave it there
        try_guess(4'd1, "t2_low", 4'd1, 3'd1, 7'd0, 1'b1, 2'b01);
        try_guess(4'd3, "t2_high", 4'd1, 3'd2, 7'd0, 1'b1, 2'b10);
        try_guess(4'd2, "t2_hit", 4'd2, 3'd0, 7'd5, 1'b1, 2'b11);

        // 3: out-of-range guess ignored; widening the range makes 9 a valid (too high) guess
        try_guess(4'd9, "t3_range", 4'd2, 3'd0, 7'd0, 1'b0, 2'b00);
        Max_digit = 2'd3;
        try_guess(4'd9, "t3_wide", 4'd2, 3'd1, 7'd0, 1'b0, 2'b10);

        // 4: held submit gives one check; an edge arriving while in NEW is dropped
        Max_digit = 2'd1;
        do_reset("t4_reset");
        guess  = 4'd0;
        submit = 1'b1;
        push("t4_held", 4'd1, 3'd1, 7'd0, 1'b0, 2'b01);
        step(50);
        submit = 1'b0;
        step(4);
        compare_front();
        guess  = 4'd2;
        submit = 1'b1;
        push("t4_dual", 4'd2, 3'd0, 7'd0, 1'b0, 2'b11);
        step(1);
        submit = 1'b0;
        step(1);
        guess  = 4'd0;
        submit = 1'b1;
        step(1);
        submit = 1'b0;
        step(5);
        compare_front();

        // 5: incorrect saturates at 7, then game end freezes everything
        do_reset("t5_reset");
        for (int i = 1; i <= 8; i++) begin
            try_guess(4'd0, $sformatf("t5_miss%0d", i), 4'd1, 3'((i > 7) ? 7 : i), 7'd0,
                      1'b0, 2'b01);
        end
        WINorLOSE = 2'b00;
        step(2);
        guess  = 4'd2;
        submit = 1'b1;
        push("t5_done", 4'd1, 3'd7, 7'd0, 1'b1, 2'b01);
        step(3);
        submit = 1'b0;
        step(10);
        compare_front();

        // 5b: timer frozen mid-count once the game ends
        WINorLOSE = 2'b11;
        do_reset("t5b_reset");
        step(9);
        WINorLOSE = 2'b00;
        push("t5b_freeze", 4'd1, 3'd0, 7'd3, 1'b1, 2'b00);
        step(20);
        compare_front();

        // 6: reset asserted while a guess is in CHECK
        WINorLOSE = 2'b11;
        do_reset("t6_reset");
        try_guess(4'd0, "t6_pre", 4'd1, 3'd1, 7'd0, 1'b0, 2'b01);
        guess  = 4'd3;
        submit = 1'b1;
        step(2);
        restart = 1'b0;
        #1;
        push("t6_async", 4'd1, 3'd0, 7'd5, 1'b1, 2'b00);
        compare_front();
        submit = 1'b0;
        step(2);
        restart = 1'b1;
        push("t6_lost", 4'd1, 3'd0, 7'd0, 1'b0, 2'b00);
        step(6);
        compare_front();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
